// File: rtl/pc_gen_multi_if.sv
// pc_gen_multi_if: control, redirect and status signals between the fetch PC generator and its pipeline
interface pc_gen_multi_if #(
  parameter int XLEN = 32,
  parameter int CW = 3
);
  logic stall_i;
  logic halt_i;
  logic trap_i;
  logic mret_i;
  logic br_taken_i;
  logic [XLEN-1:0] br_base_i;
  logic [XLEN-1:0] br_offset_i;
  logic jmp_i;
  logic [XLEN-1:0] jmp_target_i;
  logic call_i;
  logic ret_i;
  logic [XLEN-1:0] ret_fallback_i;
  logic [XLEN-1:0] pc_o;
  logic pc_valid_o;
  logic [XLEN-1:0] epc_o;
  logic [CW-1:0] ras_count_o;
  modport master (
    output stall_i, halt_i, trap_i, mret_i, br_taken_i, br_base_i, br_offset_i,
           jmp_i, jmp_target_i, call_i, ret_i, ret_fallback_i,
    input  pc_o, pc_valid_o, epc_o, ras_count_o
  );
  modport slave (
    input  stall_i, halt_i, trap_i, mret_i, br_taken_i, br_base_i, br_offset_i,
           jmp_i, jmp_target_i, call_i, ret_i, ret_fallback_i,
    output pc_o, pc_valid_o, epc_o, ras_count_o
  );
endinterface

// File: rtl/pc_gen_multi.sv
// pc_gen_multi: fetch PC generator with prioritised redirects, return-address stack and boot/run/halt control
module pc_gen_multi #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0100),
  parameter int PC_INC = 4,
  parameter int OFFSET_SHIFT = 1,
  parameter int RAS_DEPTH = 4
) (
  input logic clk_i,
  input logic rst_i,
  pc_gen_multi_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0] top_q, top_d, push_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop;
  logic [XLEN-1:0] inc;
  assign inc = XLEN'(PC_INC);
  assign push_idx = top_q + PW'(1);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    epc_d = epc_q;
    push = 1'b0;
    pop = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.trap_i) begin
          pc_d = TRAP_VECTOR;
          epc_d = pc_q;
        end else if (bus.halt_i) begin
          state_d = HALT;
        end else if (bus.mret_i) begin
          pc_d = epc_q;
        end else if (bus.br_taken_i) begin
          pc_d = bus.br_base_i + (bus.br_offset_i << OFFSET_SHIFT);
        end else if (bus.jmp_i) begin
          pc_d = bus.jmp_target_i;
          push = bus.call_i;
        end else if (bus.ret_i) begin
          pc_d = (cnt_q != '0) ? ras_q[top_q] : bus.ret_fallback_i;
          pop = (cnt_q != '0);
        end else if (!bus.stall_i) begin
          pc_d = pc_q + inc;
        end
      end
      HALT: begin
        if (bus.trap_i) begin
          state_d = RUN;
          pc_d = TRAP_VECTOR;
          epc_d = pc_q;
        end else if (!bus.halt_i) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end
  // a push onto a full stack lands on the oldest slot, so the count saturates
  always_comb begin
    ras_d = ras_q;
    top_d = top_q;
    cnt_d = cnt_q;
    if (push) begin
      ras_d[push_idx] = bus.br_base_i + inc;
      top_d = push_idx;
      cnt_d = (cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + CW'(1);
    end else if (pop) begin
      top_d = top_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q <= RESET_VECTOR;
      epc_q <= '0;
      ras_q <= '{default: '0};
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      epc_q <= epc_d;
      ras_q <= ras_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.pc_o = pc_q;
  assign bus.pc_valid_o = (state_q == RUN);
  assign bus.epc_o = epc_q;
  assign bus.ras_count_o = cnt_q;
endmodule
